fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_next_pc_sel.sv | 19 +
 rtl/fetch_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: FSM state encoding, NOP encoding, default reset PC.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    MISS_KILL = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC selection: BTB taken target or sequential PC+4 (wraps modulo 2^ADDR_WIDTH).
// Purely combinational, zero latency; no flow control of its own.
module next_pc_sel #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  btb_hit,
  input  logic                  btb_taken,
  input  logic [ADDR_WIDTH-1:0] btb_target,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  assign pc_plus4   = pc + ADDR_WIDTH'(4);
  assign pred_taken = btb_hit & btb_taken;
  assign next_pc    = pred_taken ? btb_target : pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus RUN/MISS_WAIT/MISS_KILL FSM over a blocking I-cache.
// Zero-cycle outputs; i_stall_fetch holds PC on hits, misses stall via o_miss_stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          INSTR_WIDTH = 32,
  parameter logic [63:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_stall_fetch,
  input  logic                   i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_btb_hit,
  input  logic                   i_btb_taken,
  input  logic [1:0]             i_btb_way,
  input  logic [ADDR_WIDTH-1:0]  i_btb_target,
  output logic                   o_icache_req,
  output logic [ADDR_WIDTH-1:0]  o_icache_addr,
  input  logic                   i_icache_valid,
  input  logic [INSTR_WIDTH-1:0] i_icache_instr,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_branch_pred_taken,
  output logic [1:0]             o_btb_way,
  output logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred,
  output logic                   o_log_trace,
  output logic                   o_miss_stall
);

  localparam logic [ADDR_WIDTH-1:0]  RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [INSTR_WIDTH-1:0] NOP    = INSTR_WIDTH'(NOP_INSTR);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  pred_taken;

  next_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc_sel (
    .pc         (pc_q),
    .btb_hit    (i_btb_hit),
    .btb_taken  (i_btb_taken),
    .btb_target (i_btb_target),
    .pc_plus4   (pc_plus4),
    .pred_taken (pred_taken),
    .next_pc    (next_pc)
  );

  assign o_icache_req          = 1'b1;
  assign o_icache_addr         = pc_q;
  assign o_pc                  = pc_q;
  assign o_pc_plus4            = pc_plus4;
  assign o_branch_pred_taken   = pred_taken;
  assign o_btb_way             = i_btb_way;
  assign o_pc_target_addr_pred = next_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    o_miss_stall = 1'b0;
    o_log_trace  = 1'b0;
    o_instr      = NOP;
    case (state_q)
      RUN: begin
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc;
        end else if (i_icache_valid) begin
          o_log_trace = 1'b1;
          o_instr     = i_icache_instr;
          if (!i_stall_fetch) pc_d = next_pc;
        end else begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        o_miss_stall = 1'b1;
        if (i_redirect_valid) begin
          // Refill landing with the redirect completes the kill in the same cycle.
          if (i_icache_valid) begin
            pc_d    = i_redirect_pc;
            state_d = RUN;
          end else begin
            pend_d  = i_redirect_pc;
            state_d = MISS_KILL;
          end
        end else if (i_icache_valid) begin
          state_d = RUN;
        end
      end
      MISS_KILL: begin
        o_miss_stall = 1'b1;
        if (i_redirect_valid) pend_d = i_redirect_pc;
        if (i_icache_valid) begin
          pc_d    = i_redirect_valid ? i_redirect_pc : pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= RUN;
      pc_q    <= RST_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

endmodule
